// File: rtl/wqe_fetch_if.sv
// Bundles the signals between the WQE fetch engine and the scheduler, the
// configuration and doorbell paths, the DMA read channel and the WQE cache.
interface wqe_fetch_if #(
   parameter int MAX_QP       = 32,
   parameter int QP_PTR_WIDTH = 5,
   parameter int SQ_PTR_WIDTH = 8,
   parameter int WQE_WIDTH    = 512,
   parameter int ADDR_WIDTH   = 64
);
   logic                    i_arbit_val;
   logic [QP_PTR_WIDTH-1:0] i_qp_idx;
   logic                    o_wqe_fetch_ready;
   logic [MAX_QP-1:0]       o_active;

   logic                    i_cfg_val;
   logic [QP_PTR_WIDTH-1:0] i_cfg_qp;
   logic [ADDR_WIDTH-1:0]   i_cfg_base;

   logic                    i_db_val;
   logic [QP_PTR_WIDTH-1:0] i_db_qp;
   logic [SQ_PTR_WIDTH:0]   i_db_tail;

   logic                    o_dma_req_val;
   logic                    i_dma_req_rdy;
   logic [ADDR_WIDTH-1:0]   o_dma_req_addr;
   logic [15:0]             o_dma_req_len;

   logic                    i_dma_rsp_val;
   logic                    i_dma_rsp_last;
   logic [WQE_WIDTH-1:0]    i_dma_rsp_data;

   logic                    o_wqe_wr_en;
   logic [QP_PTR_WIDTH-1:0] o_wqe_qp;
   logic [WQE_WIDTH-1:0]    o_wqe_data;
   logic                    o_err;

   modport slave (
      input  i_arbit_val, i_qp_idx, i_cfg_val, i_cfg_qp, i_cfg_base,
             i_db_val, i_db_qp, i_db_tail, i_dma_req_rdy,
             i_dma_rsp_val, i_dma_rsp_last, i_dma_rsp_data,
      output o_wqe_fetch_ready, o_active, o_dma_req_val, o_dma_req_addr,
             o_dma_req_len, o_wqe_wr_en, o_wqe_qp, o_wqe_data, o_err
   );

   modport master (
      output i_arbit_val, i_qp_idx, i_cfg_val, i_cfg_qp, i_cfg_base,
             i_db_val, i_db_qp, i_db_tail, i_dma_req_rdy,
             i_dma_rsp_val, i_dma_rsp_last, i_dma_rsp_data,
      input  o_wqe_fetch_ready, o_active, o_dma_req_val, o_dma_req_addr,
             o_dma_req_len, o_wqe_wr_en, o_wqe_qp, o_wqe_data, o_err
   );
endinterface

// File: rtl/wqe_fetch_engine.sv
// Turns a scheduler grant into one DMA read of up to MAX_BURST WQEs from the
// granted QP's send ring, streams the beats into the WQE cache, then advances head.
module wqe_fetch_engine #(
   parameter int MAX_QP       = 32,
   parameter int QP_PTR_WIDTH = 5,
   parameter int SQ_PTR_WIDTH = 8,
   parameter int WQE_WIDTH    = 512,
   parameter int MAX_BURST    = 4,
   parameter int ADDR_WIDTH   = 64
) (
   input logic          clk,
   input logic          rst_n,
   wqe_fetch_if.slave   bus
);
   localparam int PW         = SQ_PTR_WIDTH + 1;
   localparam int WQE_BYTES  = WQE_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(WQE_BYTES);
   localparam int CNT_W      = $clog2(MAX_BURST + 1);

   typedef enum logic [2:0] {IDLE, CALC, REQ, RSP, UPD} state_t;

   state_t                  state;
   logic [PW-1:0]           head [MAX_QP];
   logic [PW-1:0]           tail [MAX_QP];
   logic [ADDR_WIDTH-1:0]   base [MAX_QP];
   logic [QP_PTR_WIDTH-1:0] cur_qp;
   logic [CNT_W-1:0]        cur_cnt;
   logic [PW-1:0]           beats;

   logic [PW-1:0]           avail;
   logic [SQ_PTR_WIDTH-1:0] head_idx;
   logic [PW-1:0]           room;
   logic [PW-1:0]           burst;
   logic [CNT_W-1:0]        calc_cnt;
   logic [ADDR_WIDTH-1:0]   calc_addr;
   logic [15:0]             calc_len;

   // Burst size is clipped by what is posted and by the ring end so one read never wraps.
   always_comb begin
      avail    = tail[cur_qp] - head[cur_qp];
      head_idx = head[cur_qp][SQ_PTR_WIDTH-1:0];
      room     = (PW'(1) << SQ_PTR_WIDTH) - {1'b0, head_idx};
      burst    = PW'(MAX_BURST);
      if (avail < burst) burst = avail;
      if (room < burst) burst = room;
      calc_cnt  = CNT_W'(burst);
      calc_addr = base[cur_qp] + (ADDR_WIDTH'(head_idx) << BYTE_SHIFT);
      calc_len  = 16'(calc_cnt) << BYTE_SHIFT;
   end

   always_comb begin
      bus.o_active = '0;
      for (int q = 0; q < MAX_QP; q++) bus.o_active[q] = (head[q] != tail[q]);
   end

   // Configuration wins over a doorbell; head advance from UPD and tail from a doorbell may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int q = 0; q < MAX_QP; q++) begin
            head[q] <= '0;
            tail[q] <= '0;
            base[q] <= '0;
         end
      end else begin
         for (int q = 0; q < MAX_QP; q++) begin
            if (bus.i_cfg_val && bus.i_cfg_qp == QP_PTR_WIDTH'(q)) begin
               base[q] <= bus.i_cfg_base;
               head[q] <= '0;
               tail[q] <= '0;
            end else begin
               if (bus.i_db_val && bus.i_db_qp == QP_PTR_WIDTH'(q)) tail[q] <= bus.i_db_tail;
               if (state == UPD && cur_qp == QP_PTR_WIDTH'(q)) head[q] <= head[q] + PW'(cur_cnt);
            end
         end
      end
   end

   // Fetch sequencer; every output it drives is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         cur_qp                <= '0;
         cur_cnt               <= '0;
         beats                 <= '0;
         bus.o_wqe_fetch_ready <= 1'b1;
         bus.o_dma_req_val     <= 1'b0;
         bus.o_dma_req_addr    <= '0;
         bus.o_dma_req_len     <= '0;
         bus.o_wqe_wr_en       <= 1'b0;
         bus.o_wqe_qp          <= '0;
         bus.o_wqe_data        <= '0;
         bus.o_err             <= 1'b0;
      end else begin
         bus.o_wqe_wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_arbit_val) begin
                  cur_qp                <= bus.i_qp_idx;
                  bus.o_wqe_fetch_ready <= 1'b0;
                  state                 <= CALC;
               end
            end
            CALC: begin
               if (avail == '0) begin
                  bus.o_wqe_fetch_ready <= 1'b1;
                  state                 <= IDLE;
               end else begin
                  cur_cnt            <= calc_cnt;
                  bus.o_dma_req_addr <= calc_addr;
                  bus.o_dma_req_len  <= calc_len;
                  bus.o_dma_req_val  <= 1'b1;
                  state              <= REQ;
               end
            end
            REQ: begin
               if (bus.i_dma_req_rdy) begin
                  bus.o_dma_req_val <= 1'b0;
                  beats             <= '0;
                  state             <= RSP;
               end
            end
            RSP: begin
               if (bus.i_dma_rsp_val) begin
                  bus.o_wqe_wr_en <= 1'b1;
                  bus.o_wqe_qp    <= cur_qp;
                  bus.o_wqe_data  <= bus.i_dma_rsp_data;
                  beats           <= beats + PW'(1);
                  if (beats >= PW'(cur_cnt)) bus.o_err <= 1'b1;
                  if (bus.i_dma_rsp_last) begin
                     if (beats + PW'(1) != PW'(cur_cnt)) bus.o_err <= 1'b1;
                     state <= UPD;
                  end
               end
            end
            UPD: begin
               bus.o_wqe_fetch_ready <= 1'b1;
               state                 <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/wqe_fetch_engine.md
Name: wqe_fetch_engine

Overview:
- Sits directly downstream of the WQE read scheduler.
- Consumes the scheduler's granted QP index, reads that QP's send-queue head/tail pointers and issues one DMA read for a burst of WQEs from host memory.
- Streams the returned WQEs into the WQE cache.
- Drives the scheduler's fetch-ready input and per-QP active vector, closing the arbitration loop.

Parameters:
- MAX_QP, 32, number of QPs.
- QP_PTR_WIDTH, 5, log2(MAX_QP).
- SQ_PTR_WIDTH, 8, log2 of send-queue depth per QP (depth 256 WQEs).
- WQE_WIDTH, 512, bits per WQE; one DMA response beat = one WQE; WQE_BYTES = WQE_WIDTH/8.
- MAX_BURST, 4, maximum WQEs per DMA read.
- ADDR_WIDTH, 64, host address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_arbit_val  in  1  scheduler grant valid, 1-cycle pulse.
- i_qp_idx  in  QP_PTR_WIDTH  granted QP.
- o_wqe_fetch_ready  out  1  engine idle, may accept a grant.
- o_active  out  MAX_QP  bit q = (head[q] != tail[q]).
- i_cfg_val  in  1  QP configure strobe.
- i_cfg_qp  in  QP_PTR_WIDTH  QP being configured.
- i_cfg_base  in  ADDR_WIDTH  SQ base address, WQE_BYTES aligned.
- i_db_val  in  1  doorbell strobe.
- i_db_qp  in  QP_PTR_WIDTH  doorbell QP.
- i_db_tail  in  SQ_PTR_WIDTH+1  new tail including wrap bit.
- o_dma_req_val  out  1  read request valid.
- i_dma_req_rdy  in  1  read request accepted.
- o_dma_req_addr  out  ADDR_WIDTH  request address.
- o_dma_req_len  out  16  request length in bytes.
- i_dma_rsp_val  in  1  response beat valid; no backpressure.
- i_dma_rsp_last  in  1  final beat of response.
- i_dma_rsp_data  in  WQE_WIDTH  one WQE.
- o_wqe_wr_en  out  1  cache write strobe.
- o_wqe_qp  out  QP_PTR_WIDTH  owning QP.
- o_wqe_data  out  WQE_WIDTH  WQE payload.
- o_err  out  1  sticky beat-count mismatch flag.

Behaviour:
Reset values:
- All outputs 0 except o_wqe_fetch_ready = 1.
- All head, tail and base registers 0; FSM in IDLE.

Pointers:
- SQ_PTR_WIDTH+1 bits each; the MSB is the wrap bit.
- Index = low SQ_PTR_WIDTH bits.
- avail = (tail - head) mod 2^(SQ_PTR_WIDTH+1).

FSM states: IDLE, CALC, REQ, RSP, UPD.
- IDLE: o_wqe_fetch_ready = 1. When i_arbit_val = 1: latch i_qp_idx and go to CALC. The ready output is registered and is 0 from the next cycle.
- CALC (1 cycle):
  - cnt = min(avail, MAX_BURST, 2^SQ_PTR_WIDTH - head_idx), so a burst never crosses the ring end.
  - If avail = 0, go to IDLE with no request. This is a stale grant.
  - Otherwise compute addr = base + head_idx*WQE_BYTES and len = cnt*WQE_BYTES, then go to REQ.
- REQ:
  - o_dma_req_val = 1; addr and len are held stable until i_dma_req_rdy.
  - On the handshake cycle, go to RSP.
- RSP:
  - Each i_dma_rsp_val beat produces the same-cycle-registered output o_wqe_wr_en = 1 with o_wqe_qp = latched QP and o_wqe_data = beat data. Write latency is 1 cycle.
  - A beat counter counts up.
  - On i_dma_rsp_last go to UPD. If beats != cnt, set o_err.
  - If beats reach cnt without last, keep waiting for last. Extra beats are still written, and o_err is set.
- UPD (1 cycle): head[qp] += cnt (mod 2^(SQ_PTR_WIDTH+1)), then go to IDLE.
- Minimum grant-to-ready turnaround: 4 + DMA latency cycles.

Grant and doorbell rules:
- i_arbit_val while not in IDLE is ignored; no error is raised.
- Doorbell writes tail[i_db_qp] at any time, including for the in-flight QP; cnt is already frozen in CALC.
- A doorbell in the same cycle as UPD on the same QP: both registers update (tail from the doorbell, head from UPD).
- o_active is combinational from the registered head/tail. It reflects a doorbell 1 cycle after the strobe and reflects UPD 1 cycle after UPD.

Configuration rules:
- Config sets base[q] = i_cfg_base and head[q] = tail[q] = 0.
- Software configures only idle QPs. If config hits the in-flight QP, the in-flight fetch completes, UPD still applies, and the result is undefined. The bench must not rely on it.
- Config has priority over a doorbell on the same QP in the same cycle.

Reset mid-operation: asynchronous return to IDLE and reset values; any outstanding DMA response is the responsibility of the external reset domain.

Test Plan:
1. cfg QP3 base 0x1000_0000; doorbell QP3 tail 3; grant QP3 -> one request, addr 0x1000_0000, len 192; 3 beats give 3 wr_en with qp 3; head[3] = 3; o_active[3] = 0; ready returns to 1.
2. QP5 head 254, doorbell tail 260 (wrap bit set, idx 4) -> first grant: len 128 (2 WQEs, stops at ring end), head 256 (idx 0, wrap 1); second grant: len 256 (4 WQEs) at base+0.
3. Grant to QP7 with head == tail -> no o_dma_req_val; ready returns 1 within 2 cycles; o_err stays 0.
4. Hold i_dma_req_rdy low for 10 cycles -> val, addr and len stay constant; exactly one request is accepted.
5. Doorbell on the in-flight QP during RSP, and in the same cycle as UPD -> the burst length is unchanged; afterwards head = old_head + cnt and tail = doorbell value; o_active matches.
6. Request cnt 4, response last on beat 2 -> 2 writes; o_err = 1 and stays set; ready returns; the next fetch completes normally.
